// File: rtl/fft_sdf_sequencer.sv
// Control sequencer for a radix-2 single-path delay-feedback FFT pipeline.
// One enabled-cycle counter g drives every stage's butterfly select and twiddle
// address; fill/run/drain phases gate the shared pipeline enable and tag the
// bit-reversed samples leaving the last stage with their natural-order bin.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid, in_ready  sample handshake from the source
//   flush               drain request (level or pulse, latched until a frame boundary)
//   enable              pipeline advance for every stage
//   ctrl[s]             butterfly/delay select of stage s
//   address[16s+:16]    twiddle address of stage s
//   out_valid/first/last, out_index   tags for the sample leaving the last stage
//   busy                sequencer not idle
module fft_sdf_sequencer #(
  parameter int unsigned FFT_N = 1024,
  parameter int unsigned LOG2N = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   enable,
  output logic [LOG2N-1:0]       ctrl,
  output logic [16*LOG2N-1:0]    address,
  output logic                   out_valid,
  output logic                   out_first,
  output logic                   out_last,
  output logic [LOG2N-1:0]       out_index,
  output logic                   busy
);

  localparam logic [LOG2N-1:0] LastPos = LOG2N'(FFT_N - 1);
  localparam logic [LOG2N-1:0] One     = LOG2N'(1);

  typedef enum logic [1:0] {StIdle, StFill, StRun, StDrain} state_e;

  state_e           state_q, state_d;
  logic [LOG2N-1:0] g_q, g_d;
  logic [LOG2N-1:0] fill_q, fill_d;
  logic [LOG2N-1:0] drain_q, drain_d;
  logic             flush_pend_q, flush_pend_d;

  logic [LOG2N-1:0] fill_inc;
  logic [LOG2N-1:0] pos;
  logic [LOG2N-1:0] index_rev;
  logic             boundary;

  assign fill_inc = fill_q + One;
  // Position of the sample leaving the last stage, one ahead of g.
  assign pos      = g_q + One;
  // A pending or present flush is honoured only on a frame boundary.
  assign boundary = (flush | flush_pend_q) & (g_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      g_q          <= '0;
      fill_q       <= '0;
      drain_q      <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      g_q          <= g_d;
      fill_q       <= fill_d;
      drain_q      <= drain_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    g_d          = g_q;
    fill_d       = fill_q;
    drain_d      = drain_q;
    flush_pend_d = flush_pend_q;
    in_ready     = 1'b0;
    enable       = 1'b0;
    out_valid    = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready     = 1'b1;
        enable       = in_valid;
        flush_pend_d = 1'b0;
        g_d          = '0;
        fill_d       = '0;
        drain_d      = '0;
        if (in_valid) begin
          g_d     = One;
          fill_d  = One;
          state_d = StFill;
        end
      end
      StFill, StRun: begin
        if (boundary) begin
          // The sample offered this cycle is refused; drain starts next cycle.
          state_d      = StDrain;
          drain_d      = LastPos;
          flush_pend_d = 1'b0;
        end else begin
          in_ready     = 1'b1;
          enable       = in_valid;
          flush_pend_d = flush_pend_q | flush;
          if (enable) begin
            g_d = pos;
          end
          if (state_q == StFill && enable) begin
            fill_d = fill_inc;
            if (fill_inc == LastPos) begin
              state_d = StRun;
            end
          end
          if (state_q == StRun) begin
            out_valid = enable;
          end
        end
      end
      StDrain: begin
        enable    = 1'b1;
        out_valid = 1'b1;
        g_d       = pos;
        drain_d   = drain_q - One;
        if (drain_q == One) begin
          state_d = StIdle;
          g_d     = '0;
          drain_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (!rst_n) begin
      in_ready  = 1'b0;
      enable    = 1'b0;
      out_valid = 1'b0;
    end
  end

  for (genvar s = 0; s < LOG2N; s++) begin : gen_stage
    assign ctrl[s]      = g_q[LOG2N-1-s];
    assign index_rev[s] = pos[LOG2N-1-s];
    if (s < LOG2N - 1) begin : gen_addr
      assign address[16*s +: 16] = 16'(g_q[LOG2N-2-s:0]);
    end else begin : gen_addr_zero
      assign address[16*s +: 16] = '0;
    end
  end

  // Index is only meaningful with out_valid; held at zero otherwise.
  assign out_index = out_valid ? index_rev : '0;
  assign out_first = out_valid && (pos == '0);
  assign out_last  = out_valid && (pos == LastPos);
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_fft_sdf_sequencer.sv
// Scoreboard bench for fft_sdf_sequencer at FFT_N=16. Stimulus pushes the
// expected tag of every sample that should emerge; a negedge monitor pops and
// compares whenever out_valid is high.
module tb_fft_sdf_sequencer;

  localparam int N = 16;
  localparam int L = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          flush;
  logic          enable;
  logic [L-1:0]  ctrl;
  logic [16*L-1:0] address;
  logic          out_valid;
  logic          out_first;
  logic          out_last;
  logic [L-1:0]  out_index;
  logic          busy;

  fft_sdf_sequencer #(
    .FFT_N (N),
    .LOG2N (L)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .enable    (enable),
    .ctrl      (ctrl),
    .address   (address),
    .out_valid (out_valid),
    .out_first (out_first),
    .out_last  (out_last),
    .out_index (out_index),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         first;
    logic         last;
    logic [3:0]   idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  // Natural-order bin emerging at position p (4-bit bit reversal).
  int bitrev_tab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected out_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_index", out_index, mon_e.idx);
        check("out_first", out_first, mon_e.first);
        check("out_last", out_last, mon_e.last);
      end
    end else begin
      check("tags without out_valid", {out_first, out_last}, 0);
    end
  end

  // One cycle: drive inputs after the edge, queue the expected emission, sample at negedge.
  task automatic tick(input logic rst, input logic iv, input logic fl, input logic emit,
                      input int p);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n    = rst;
    in_valid = iv;
    flush    = fl;
    if (emit) begin
      e.first = (p == 0);
      e.last  = (p == N - 1);
      e.idx   = 4'(bitrev_tab[p]);
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic check_g(input int g);
    check("ctrl0", ctrl[0], g >= 8);
    check("ctrl1", ctrl[1], (g / 4) % 2);
    check("ctrl2", ctrl[2], (g / 2) % 2);
    check("ctrl3", ctrl[3], g % 2);
    check("addr0", address[15:0], g % 8);
    check("addr1", address[31:16], g % 4);
    check("addr2", address[47:32], g % 2);
    check("addr3", address[63:48], 0);
  endtask

  // k-th accepted sample of a stream (1-based); it sits at g=(k-1) mod N.
  task automatic sample(input int k, input logic fl);
    tick(1'b1, 1'b1, fl, k >= N, k % N);
    check("enable", enable, 1);
    check("in_ready", in_ready, 1);
    check("busy", busy, k > 1);
    check_g((k - 1) % N);
  endtask

  task automatic drain_cycle(input int c);
    tick(1'b1, 1'b0, 1'b0, 1'b1, c);
    check("drain enable", enable, 1);
    check("drain in_ready", in_ready, 0);
    check("drain busy", busy, 1);
    check_g(c - 1);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    flush    = 1'b0;

    // Reset held with in_valid high.
    repeat (3) begin
      @(negedge clk);
      check("rst enable", enable, 0);
      check("rst in_ready", in_ready, 0);
      check("rst ctrl", ctrl, 0);
      check("rst address", address, 0);
      check("rst out_valid", out_valid, 0);
      check("rst busy", busy, 0);
    end
    tick(1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("post-rst in_ready", in_ready, 1);
    check("post-rst busy", busy, 0);

    // Continuous stream: two frames, then onward to g=6.
    for (int k = 1; k <= 38; k++) sample(k, 1'b0);

    // Stall at g=6.
    repeat (5) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0, 0);
      check("stall enable", enable, 0);
      check("stall in_ready", in_ready, 1);
      check("stall busy", busy, 1);
      check_g(6);
    end

    // Resume, flush pulse at g=5, frame completes normally.
    for (int k = 39; k <= 64; k++) sample(k, k == 54);

    // Boundary: sample refused, drain follows.
    tick(1'b1, 1'b1, 1'b0, 1'b0, 0);
    check("bound in_ready", in_ready, 0);
    check("bound enable", enable, 0);
    check("bound busy", busy, 1);
    check_g(0);
    for (int c = 1; c < N; c++) drain_cycle(c);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("after drain busy", busy, 0);
    check("after drain in_ready", in_ready, 1);
    check_g(0);

    // Flush while idle is ignored.
    tick(1'b1, 1'b0, 1'b1, 1'b0, 0);
    check("idle flush busy", busy, 0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("idle flush busy2", busy, 0);
    for (int k = 1; k <= N; k++) sample(k, 1'b0);

    // Flush exactly at g==0 with a sample offered.
    tick(1'b1, 1'b1, 1'b1, 1'b0, 0);
    check("g0 flush in_ready", in_ready, 0);
    check("g0 flush enable", enable, 0);
    for (int c = 1; c <= 3; c++) drain_cycle(c);

    // Reset on drain cycle 4.
    tick(1'b0, 1'b0, 1'b0, 1'b0, 0);
    check("mid-drain rst enable", enable, 0);
    check("mid-drain rst in_ready", in_ready, 0);
    check("mid-drain rst out_valid", out_valid, 0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("rst-idle busy", busy, 0);
    check("rst-idle ctrl", ctrl, 0);
    check("rst-idle address", address, 0);
    check("rst-idle out_index", out_index, 0);
    check("rst-idle out_valid", out_valid, 0);
    check("rst-idle in_ready", in_ready, 1);

    for (int k = 1; k <= N; k++) sample(k, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("scoreboard pending entries", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fft_sdf_sequencer.md
# fft_sdf_sequencer

Control sequencer for the radix-2 single-path delay-feedback (SDF) FFT pipeline, a chain of LOG2N `stage` instances numbered 0..LOG2N-1. It gates the pipeline with a shared `enable` and drives each stage's butterfly/delay select `ctrl` and twiddle `address` from one enabled-cycle counter. It runs fill, steady-state and drain phases, and tags emerging bit-reversed samples with `out_valid`, frame markers and their natural-order bin index. It sits between the sample source and the stage chain; the datapath itself stays outside this block.

## Interface
- FFT_N, 1024: transform length; power of two, 4..32768.
- LOG2N, 10: log2(FFT_N).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  source presents a sample this cycle.
- in_ready  out  1  sample is accepted when in_valid && in_ready.
- flush  in  1  request to drain after the current frame; level or pulse, latched.
- enable  out  1  pipeline advance; drives `enable` of every stage.
- ctrl  out  LOG2N  bit s drives `ctrl` of stage s.
- address  out  16*LOG2N  bits [16s+15:16s] drive `address` of stage s.
- out_valid  out  1  the last stage's X_out is a real FFT sample this cycle.
- out_first  out  1  with out_valid: first sample of a frame (bin 0).
- out_last  out  1  with out_valid: last sample of a frame.
- out_index  out  LOG2N  natural-order bin index of the emerging sample.
- busy  out  1  state != IDLE.

## Operation
- Stage s has half-span M_s = FFT_N/2^(s+1). The total pipeline latency is the sum of M_s, which is FFT_N-1 enabled cycles.
- g is a LOG2N-bit enabled-cycle counter. It increments mod FFT_N on every cycle with enable=1 and is held otherwise.
- ctrl[s] = g[LOG2N-1-s].
- address slice s = g[LOG2N-2-s:0], zero-extended to 16 bits. Stage LOG2N-1 gets address 0.
- Emerging position p = (g+1) mod FFT_N.
  - out_index = bit-reverse of p over LOG2N bits.
  - out_first = out_valid && p==0.
  - out_last = out_valid && p==FFT_N-1.
- States:
  - IDLE: g=0, fill=0, flush_pend=0. in_ready=1, enable=in_valid. An accepted sample moves to FILL.
  - FILL: enable = in_valid && in_ready. The fill counter (LOG2N bits) increments per enabled cycle. When it reaches FFT_N-1, go to RUN. out_valid=0.
  - RUN: enable = in_valid && in_ready; out_valid = enable.
  - DRAIN: in_ready=0, enable=1, out_valid=1. A drain counter loads FFT_N-1 on entry and decrements each cycle. After its last cycle (g=FFT_N-2), go to IDLE with g=0.
- flush handling:
  - flush in FILL or RUN sets flush_pend.
  - flush in IDLE or DRAIN is ignored.
  - While (flush || flush_pend) && g==0 in FILL or RUN, in_ready=0. In that case the next state is DRAIN, which is entered only on frame boundaries.
- Stall: in_valid=0 in FILL or RUN gives enable=0. g, fill, ctrl, address and state all hold, and out_valid=0.
- Simultaneous in_valid and a boundary flush: flush wins; the sample is not accepted.

## Timing
- ctrl, address, out_index, out_first and out_last decode combinationally from registered g. There is no added latency; they are valid in the same cycle as enable.
- enable, in_ready and out_valid are combinational from state, g and in_valid. No registered output depends on in_valid within the same cycle.
- First out_valid occurs on the FFT_N-th accepted sample (g=FFT_N-1), with out_index=0.
- Drain lasts exactly FFT_N-1 cycles. It emits p=1..FFT_N-1, and out_last occurs on the final drain cycle.
- Reset behaviour (rst_n=0 at an edge):
  - Next cycle: state IDLE, g=0, fill=0, flush_pend=0, drain=0.
  - Every output is 0 except in_ready. This includes ctrl, address, out_index and busy.
  - in_ready and enable are forced to 0 while rst_n=0.
  - Reset mid-FILL, mid-RUN or mid-DRAIN aborts immediately; in-flight data is discarded.

## Test plan
- Reset: rst_n=0 for 3 cycles with in_valid=1 -> enable=0, in_ready=0, ctrl=0, address=0, out_valid=0, busy=0. One cycle after release: in_ready=1, busy=0.
- FFT_N=16, continuous in_valid=1 from reset release:
  - ctrl[0] is 0 for 8 enabled cycles, then 1 for 8.
  - ctrl[3] toggles every cycle; stage 1 address cycles 0,1,2,3.
  - out_valid first rises on the 16th accepted sample with out_first=1, out_index=0.
  - Subsequent out_index values: 8,4,12,2,...,15; out_last appears on the 31st accepted sample.
- Stall: with g=6, drop in_valid for 5 cycles -> enable=0, ctrl/address frozen at g=6, out_valid=0. Resume -> g=7, and the sequence matches the unstalled run.
- Flush mid-frame:
  - After 2 full frames, pulse flush at g=5 -> in_ready stays 1 until g wraps to 0.
  - Then in_ready=0 and DRAIN: enable=1 for 15 cycles, out_valid=1 throughout, out_index 8,4,...,15, out_last on cycle 15.
  - Then busy=0 and g=0.
- Flush in IDLE -> ignored; the next stream behaves exactly as in the continuous-stream test. Flush exactly at g==0 with in_valid=1 -> sample not accepted, DRAIN entered next cycle.
- Reset mid-DRAIN at drain cycle 4 -> IDLE next cycle with all outputs 0. A new stream restarts at g=0; first out_valid on its 16th sample.
